// File: rtl/viterbi_pkg.sv
// Shared trellis constants for the convolutional encoder and the Viterbi decoder.
// Both sides import these values so their polynomials and state widths always agree.
package viterbi_pkg;

  localparam int CONV_K = 4;
  localparam logic [CONV_K-1:0] CONV_G0 = 4'b1111;
  localparam logic [CONV_K-1:0] CONV_G1 = 4'b1101;
  localparam int SR_W = CONV_K - 1;
  localparam int NUM_STATES = 1 << SR_W;
  localparam int CNT_W = $clog2(CONV_K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/conv_parity.sv
// Parity of a tap vector against one generator polynomial (purely combinational).
module conv_parity #(
  parameter int W = 4
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] poly,
  output logic         p
);

  assign p = ^(v & poly);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 zero-terminated feedforward convolutional encoder with a
// ready/valid input and a single registered output symbol slot.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int              K  = CONV_K,
  parameter logic [K-1:0]    G0 = CONV_G0,
  parameter logic [K-1:0]    G1 = CONV_G1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
);

  localparam int SW = K - 1;
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] TAIL_END = CW'(K - 2);

  enc_state_e state, state_d;
  logic [SW-1:0] sr;
  logic [CW-1:0] tcnt;
  logic          load;
  logic          accept;
  logic          tail_step;
  logic          tail_done;
  logic          shift;
  logic          b;
  logic [K-1:0]  v;
  logic          p0;
  logic          p1;

  // The output slot refills whenever it is empty or being drained this cycle.
  assign load      = !out_valid || out_ready;
  assign in_ready  = load && (state != TAIL);
  assign accept    = in_valid && in_ready;
  assign tail_step = (state == TAIL) && load;
  assign tail_done = tail_step && (tcnt == TAIL_END);
  assign shift     = accept || tail_step;
  assign b         = (state == TAIL) ? 1'b0 : in_bit;
  assign v         = {b, sr};
  assign busy      = (state != IDLE) || out_valid;

  conv_parity #(.W(K)) u_par0 (
    .v    (v),
    .poly (G0),
    .p    (p1)
  );

  conv_parity #(.W(K)) u_par1 (
    .v    (v),
    .poly (G1),
    .p    (p0)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DATA: begin
        if (accept) state_d = in_last ? TAIL : DATA;
      end
      TAIL: begin
        if (tail_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Shift register, tail counter and output symbol slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      tcnt      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pair  <= 2'b00;
    end else begin
      if (shift) begin
        sr        <= v[K-1:1];
        out_pair  <= {p1, p0};
        out_last  <= tail_done;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (tail_step) tcnt <= tail_done ? '0 : tcnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: hand-computed symbol streams, stalls,
// back-to-back frames, mid-frame reset and a small independent encoder model.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_pair;
  logic       out_last;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [2:0] got_q[$];
  int         got_cyc[$];
  logic       prev_stall = 1'b0;
  logic [2:0] prev_sym = 3'b000;
  bit         rand_ready = 1'b0;
  bit         count_ir = 1'b0;
  int         ir_low = 0;

  conv_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Capture consumed symbols and verify outputs hold steady while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sym", {out_pair, out_last}, prev_sym);
      end
      prev_stall = out_valid && !out_ready;
      prev_sym   = {out_pair, out_last};
      if (out_valid && out_ready) begin
        got_q.push_back({out_pair, out_last});
        got_cyc.push_back(cyc);
      end
      if (count_ir && !in_ready) ir_low++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_frame(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      bit done;
      t = 0;
      done = 1'b0;
      in_valid = 1'b1;
      in_bit   = bits[n-1-i];
      in_last  = (i == n - 1);
      while (!done) begin
        @(negedge clk);
        if (in_ready) done = 1'b1;
        @(posedge clk);
        #1;
        t++;
        if (!done && t > 200) begin
          chk("accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_syms(input string tag, input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), n);
  endtask

  task automatic check_seq(input string tag, input logic [2:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_sym%0d", tag, i), got_q[i], exp[i]);
      else chk($sformatf("%s_sym%0d_missing", tag, i), 0, 1);
    end
  endtask

  task automatic model_frame(input logic [31:0] bits, input int n, output logic [2:0] exp[$]);
    logic [2:0] s;
    logic       bb;
    s = 3'b000;
    exp.delete();
    for (int i = 0; i < n + 3; i++) begin
      bb = (i < n) ? bits[n-1-i] : 1'b0;
      exp.push_back({bb ^ s[2] ^ s[1] ^ s[0], bb ^ s[2] ^ s[0], i == n + 2});
      s = {bb, s[2:1]};
    end
  endtask

  initial begin
    logic [2:0] exp1[$];
    logic [2:0] exp2[$];
    logic [2:0] exp_bb[$];
    logic [2:0] expr[$];
    logic [31:0] rbits;
    int rn;

    exp1 = '{3'b110, 3'b110, 3'b010, 3'b110, 3'b010, 3'b010, 3'b111};
    exp2 = '{3'b110, 3'b110, 3'b100, 3'b111};

    rst = 1'b1;
    in_valid = 1'b0;
    in_bit = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pair", out_pair, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;

    // Frame 1,0,1,1 with the sink always ready.
    send_frame(32'b1011, 4);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_syms("f1", 7);
    check_seq("f1", exp1);
    chk("f1_sr_zero", dut.sr, 0);
    chk("f1_busy_end", busy, 0);

    // Single-bit frame.
    got_q.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    send_frame(32'b1, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_syms("f2", 4);
    check_seq("f2", exp2);

    // Same 4-bit frame under random backpressure.
    got_q.delete();
    got_cyc.delete();
    rand_ready = 1'b1;
    @(posedge clk);
    #2;
    send_frame(32'b1011, 4);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_syms("stall", 7);
    check_seq("stall", exp1);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back frames with in_valid held high.
    got_q.delete();
    got_cyc.delete();
    ir_low = 0;
    count_ir = 1'b1;
    send_frame(32'b1011, 4);
    send_frame(32'b1, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_syms("b2b", 11);
    count_ir = 1'b0;
    exp_bb = {exp1, exp2};
    check_seq("b2b", exp_bb);
    chk("b2b_in_ready_low", ir_low, 6);
    if (got_cyc.size() == 11) chk("b2b_no_gap", got_cyc[10] - got_cyc[0], 10);
    else chk("b2b_no_gap_count", got_cyc.size(), 11);

    // Reset in the middle of a frame with a symbol pending.
    got_q.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    in_bit = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", out_valid, 1);
    chk("mid_busy", busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_pair", out_pair, 0);
    chk("mrst_sr", dut.sr, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    got_q.delete();
    got_cyc.delete();
    send_frame(32'b1011, 4);
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_syms("after_rst", 7);
    check_seq("after_rst", exp1);

    // Random frames against the independent model, with backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      rn = $urandom_range(1, 10);
      rbits = $urandom;
      model_frame(rbits, rn, expr);
      got_q.delete();
      got_cyc.delete();
      @(posedge clk);
      #2;
      send_frame(rbits, rn);
      in_valid = 1'b0;
      in_last = 1'b0;
      wait_syms($sformatf("rnd%0d", f), rn + 3);
      check_seq($sformatf("rnd%0d", f), expr);
    end
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
